// File: rtl/conv_frame_writer_pkg.sv
// Shared definitions for the convolution output path.
//   - Default frame geometry and channel widths, shared by this writer
//     and the convolution buffer.
//   - FSM state encoding for the frame writer.
//   - Layout of one frame-buffer write entry at the default widths.
//     The writer's FIFO stores entries flat, in the same field order,
//     so non-default widths also work.
package conv_frame_writer_pkg;

  localparam int DEF_WIDTH      = 640;
  localparam int DEF_HEIGHT     = 480;
  localparam int DEF_CH_IN_W    = 12;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_W     = 19;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // One pending frame-buffer write. The address is in the MSBs and the
  // channels follow as red, green, blue.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_PIX_W-1:0]  r;
    logic [DEF_PIX_W-1:0]  g;
    logic [DEF_PIX_W-1:0]  b;
  } wr_entry_t;

endpackage

// File: rtl/conv_frame_writer_if.sv
// Bundle for the frame writer's pixel input and frame-buffer write port.
//   Pixel in : start, idval, ired, igreen, iblue
//   FB write : mem_wr_en, mem_wr_addr, mem_wr_data (out), mem_wr_ready (in)
//   Status   : busy, frame_done, overflow
// Modports:
//   master : environment side. It drives the pixels and the frame-buffer
//            ready signal.
//   slave  : the conv_frame_writer itself.
interface conv_frame_writer_if #(
  parameter int CH_IN_W = 12,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19
);
  logic               start;
  logic               idval;
  logic [CH_IN_W-1:0] ired;
  logic [CH_IN_W-1:0] igreen;
  logic [CH_IN_W-1:0] iblue;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [3*PIX_W-1:0] mem_wr_data;
  logic               mem_wr_ready;
  logic               busy;
  logic               frame_done;
  logic               overflow;

  modport master (
    output start, idval, ired, igreen, iblue, mem_wr_ready,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, busy, frame_done, overflow
  );

  modport slave (
    input  start, idval, ired, igreen, iblue, mem_wr_ready,
    output mem_wr_en, mem_wr_addr, mem_wr_data, busy, frame_done, overflow
  );
endinterface

// File: rtl/conv_frame_writer_wr_fifo.sv
// Small synchronous FIFO that absorbs frame-buffer stalls.
// It is first-word fall-through: the head entry is visible on o_rdata
// in the cycle after it is written.
//   clk, rst  : clock and synchronous active-high reset
//   i_push    : write request. It is accepted when the FIFO is not full,
//               or when it is full and a pop happens in the same cycle.
//   i_wdata   : entry to write
//   i_pop     : consume the head entry. It is ignored when the FIFO is empty.
//   o_rdata   : head entry. It reads as zero while the FIFO is empty.
//   o_empty   : status flag derived from the entry count
//   o_full    : status flag derived from the entry count
module conv_frame_writer_wr_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // When the FIFO is full, a simultaneous pop frees the slot the push
  // lands in. That slot is the head, which has already been read out.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Zero the output while empty so mem_wr_addr/data read 0 out of reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset. Only the pointers and the count
  // define which entries are valid, so resetting the data would buy
  // nothing and would stop the array from mapping to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from the values held before the edge, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by overflowing.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/conv_frame_writer.sv
// Frame writer. It takes the filtered pixel stream from the convolution
// buffer and writes one frame into the frame buffer.
// It follows the raster position (col/row, plus a running linear address).
// Each valid pixel in CAPTURE is truncated to PIX_W per channel, packed
// with its address and pushed into a small FIFO that feeds the
// frame-buffer write port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : conv_frame_writer_if.slave
//              start       arms one frame (honoured only in IDLE)
//              idval/ired/igreen/iblue  pixel stream, no backpressure
//              mem_wr_*    frame-buffer write port. en = FIFO non-empty,
//                          pop = en & ready.
//              busy        high in CAPTURE and DRAIN
//              frame_done  one-cycle pulse after the last write pops
//              overflow    sticky. A pixel was dropped this frame.
module conv_frame_writer
  import conv_frame_writer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int CH_IN_W    = DEF_CH_IN_W,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  conv_frame_writer_if.slave bus
);
  localparam int COL_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ENTRY_W = ADDR_W + 3 * PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_overflow;
  logic               r_frame_done;

  logic               w_pixel;
  logic               w_last;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wentry;
  logic [ENTRY_W-1:0] w_rentry;

  assign w_pixel = (r_state == ST_CAPTURE) && bus.idval;
  assign w_last  = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_pop   = !w_empty && bus.mem_wr_ready;
  assign w_drop  = w_pixel && w_full && !w_pop;

  // The channels are truncated by keeping their top PIX_W bits. No
  // rounding is applied.
  assign w_wentry = {r_addr,
                     bus.ired[CH_IN_W-1 -: PIX_W],
                     bus.igreen[CH_IN_W-1 -: PIX_W],
                     bus.iblue[CH_IN_W-1 -: PIX_W]};

  conv_frame_writer_wr_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pixel),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_rentry),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_CAPTURE;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // Dropped pixels still advance the position, so the pixels that
          // do land keep their correct geometry.
          if (bus.idval) begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_wr_en   = !w_empty;
  assign bus.mem_wr_addr = w_rentry[ENTRY_W-1 -: ADDR_W];
  assign bus.mem_wr_data = w_rentry[3*PIX_W-1:0];
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.frame_done  = r_frame_done;
  assign bus.overflow    = r_overflow;
endmodule
